// File: rtl/pc_fetch_stage.sv
// IF stage: PC register, next-PC selection (pc+4/branch/jump/jr) and the IF/ID pipeline latch.
// Optional misaligned-jr trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcp4,
  output logic        ifid_valid,
  output logic        misalign_exc
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pcp4;
  logic        r_ifid_valid;
  logic [31:0] w_pcp4;
  logic [31:0] w_jr_target;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_misalign;

  assign w_pcp4     = r_pc + 32'd4;
  assign w_redirect = branch_taken | jump | jr;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign  = jr & (jr_target[1:0] != 2'b00);
  assign w_jr_target = jr_target;

  always_ff @(posedge clk) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= w_misalign;
  end

  assign misalign_exc = r_misalign;
`else
  // Without the trap, a misaligned jr simply drops its low address bits.
  assign w_misalign   = 1'b0;
  assign w_jr_target  = jr_target & 32'hFFFF_FFFC;
  assign misalign_exc = 1'b0;
`endif

  always_comb begin
    w_next_pc = w_pcp4;
    if (w_misalign)        w_next_pc = EXC_VECTOR;
    else if (jr)           w_next_pc = w_jr_target;
    else if (jump)         w_next_pc = jump_addr;
    else if (branch_taken) w_next_pc = branch_target;
    else if (stall)        w_next_pc = r_pc;
  end

  // IF -> ID boundary: a redirect flushes the wrong-path fetch even while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pcp4  <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc         <= w_next_pc;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pcp4  <= w_pcp4;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_pc         <= w_next_pc;
      r_ifid_instr <= imem_rdata;
      r_ifid_pcp4  <= w_pcp4;
      r_ifid_valid <= 1'b1;
    end
  end

  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pcp4  = r_ifid_pcp4;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed cases plus randomized control traffic against a reference model.
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcp4;
  logic        ifid_valid;
  logic        misalign_exc;

  int total = 0;
  int bad   = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  pc_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_addr(jump_addr), .jr(jr), .jr_target(jr_target),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pcp4(ifid_pcp4),
    .ifid_valid(ifid_valid), .misalign_exc(misalign_exc)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = imem_fn(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state updated per rising edge.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_exc;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    logic [31:0] p4, tgt;
    logic        mis;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_exc = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      p4  = m_pc + 32'd4;
      mis = ALIGN && jr && (jr_target % 4 != 0);
      m_exc = mis;
      if (branch_taken || jump || jr) begin
        if (mis)       tgt = 32'h8000_0180;
        else if (jr)   tgt = ALIGN ? jr_target : (jr_target / 4) * 4;
        else if (jump) tgt = jump_addr;
        else           tgt = branch_target;
        m_instr = 32'h0; m_pcp4 = p4; m_valid = 1'b0; m_pc = tgt;
      end else if (!stall) begin
        m_instr = imem_fn(m_pc); m_pcp4 = p4; m_valid = 1'b1; m_pc = p4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      total++;
      if ({pc, imem_addr, ifid_instr, ifid_pcp4, ifid_valid, misalign_exc} !==
          {m_pc, m_pc, m_instr, m_pcp4, m_valid, m_exc}) begin
        bad++;
        $display("FAIL model: got pc=%h addr=%h instr=%h pcp4=%h v=%b exc=%b want pc=%h instr=%h pcp4=%h v=%b exc=%b",
                 pc, imem_addr, ifid_instr, ifid_pcp4, ifid_valid, misalign_exc,
                 m_pc, m_instr, m_pcp4, m_valid, m_exc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jr = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    jump = 1; jump_addr = a;
    cyc();
    jump = 0;
  endtask

  initial begin
    reset = 1; idle();
    branch_target = 0; jump_addr = 0; jr_target = 0;
    cyc(); cyc();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, ifid_valid}, 32'h0);
    chk("reset_instr", ifid_instr, 32'h0);
    reset = 0;
    cyc();
    chk("t1_pc", pc, 32'h4);
    chk("t1_instr", ifid_instr, 32'h0000_FFFF);
    chk("t1_valid", {31'b0, ifid_valid}, 32'h1);
    cyc(); cyc(); cyc();
    chk("t2_pc_pre", pc, 32'h10);
    go_to(32'h0040_0020);
    chk("t2_pc", pc, 32'h0040_0020);
    chk("t2_instr", ifid_instr, 32'h0);
    chk("t2_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t2_pcp4", ifid_pcp4, 32'h14);

    go_to(32'h20);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_pc_hold", pc, 32'h20);
      chk("t3_pcp4_hold", ifid_pcp4, 32'h0040_0024);
      chk("t3_valid_hold", {31'b0, ifid_valid}, 32'h0);
    end
    stall = 0;
    cyc();
    chk("t3_pc_rel", pc, 32'h24);
    chk("t3_instr_rel", ifid_instr, 32'h0020_FFDF);

    go_to(32'h30);
    stall = 1; branch_taken = 1; branch_target = 32'h100;
    cyc();
    idle();
    chk("t4_pc", pc, 32'h100);
    chk("t4_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t4_pcp4", ifid_pcp4, 32'h34);

    jr = 1; jump = 1; jr_target = 32'h200; jump_addr = 32'h300;
    cyc();
    idle();
    chk("t5_pc_jr", pc, 32'h200);
    go_to(32'hFFFF_FFFC);
    cyc();
    chk("t5_wrap_pc", pc, 32'h0);
    chk("t5_wrap_pcp4", ifid_pcp4, 32'h0);
    chk("t5_wrap_instr", ifid_instr, 32'hFFFC_0003);

    jr = 1; jr_target = 32'h202;
    cyc();
    idle();
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_pc", pc, 32'h8000_0180);
    chk("t6_exc", {31'b0, misalign_exc}, 32'h1);
`else
    chk("t6_pc", pc, 32'h200);
    chk("t6_exc", {31'b0, misalign_exc}, 32'h0);
`endif
    cyc();
    chk("t6_exc_end", {31'b0, misalign_exc}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(63) == 0);
      stall         = ($urandom_range(3) == 0);
      branch_taken  = ($urandom_range(7) == 0);
      jump          = ($urandom_range(9) == 0);
      jr            = ($urandom_range(9) == 0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_addr     = $urandom & 32'hFFFF_FFFC;
      jr_target     = ($urandom_range(1) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
      cyc();
    end
    reset = 0; idle();
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
